// File: rtl/game_pkg.sv
// Shared definitions for the game_judge block.
//   - 2-bit game state encoding (IDLE/READY/PLAY/OVER) and its typed enum
//   - LFSR seed and Fibonacci tap mask (x^8 + x^6 + x^5 + x^4 + 1)
//   - target side encoding and raw key polarity
//   - helpers: LFSR step, saturating BCD subtract
package game_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READY = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StReady = ST_READY,
    StPlay  = ST_PLAY,
    StOver  = ST_OVER
  } game_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Shift-left Fibonacci: feedback is the XOR of bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  // Raw pushbuttons are active-low, so the idle level is 1.
  localparam logic KEY_RELEASED = 1'b1;

  function automatic logic [7:0] lfsr_step(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

  // Subtract 0..3 seconds from a two-digit BCD value, saturating at 00.
  // Returns {tens, ones}.
  function automatic logic [7:0] bcd_sub(input logic [3:0] tens, input logic [3:0] ones,
                                         input logic [1:0] amt);
    logic [3:0] amt4;
    amt4 = {2'b00, amt};
    if (ones >= amt4) begin
      return {tens, ones - amt4};
    end else if (tens != 4'd0) begin
      return {tens - 4'd1, ones + 4'd10 - amt4};
    end else begin
      return 8'h00;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter and a
// registered one-cycle press pulse.
//   clock  - system clock
//   reset  - asynchronous active-low reset
//   key_n  - raw active-low pushbutton, asynchronous to clock
//   press  - one-cycle pulse on the released->pressed flip of the debounced
//            level, DEBOUNCE_CYCLES+3 cycles after the raw key falls
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_prev_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= KEY_RELEASED;
      sync2_q      <= KEY_RELEASED;
      level_q      <= KEY_RELEASED;
      level_prev_q <= KEY_RELEASED;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      // Any sample agreeing with the accepted level restarts the run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      level_prev_q <= level_q;
      press_q      <= (level_q != KEY_RELEASED) && (level_prev_q == KEY_RELEASED);
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_judge.sv
// Reaction-game judge: debounces both keys, runs the IDLE/READY/PLAY/OVER
// game FSM, picks a pseudo-random target side and judges each press.
//   clock, reset          - system clock, asynchronous active-low reset
//   key_left, key_right   - raw active-low pushbuttons
//   left, right           - one-cycle accepted-press pulses (PLAY only)
//   correct               - coincident with left/right when side == target
//   cur_state             - 00 IDLE, 01 READY, 10 PLAY, 11 OVER
//   target                - 0 left, 1 right
//   time_tens, time_ones  - BCD remaining seconds
// Build option: define GAME_JUDGE_PENALTY_EN to make a wrong press in PLAY
// cost 2 s (3 s when it lands on a tick), saturating at 00.
module game_judge
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned TICK_CYCLES       = 50000000,
  parameter int unsigned COUNTDOWN_SECONDS = 3,
  parameter int unsigned GAME_SECONDS      = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_left,
  input  logic       key_right,
  output logic       left,
  output logic       right,
  output logic       correct,
  output logic [1:0] cur_state,
  output logic       target,
  output logic [3:0] time_ones,
  output logic [3:0] time_tens
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_CYCLES - 1);

  localparam logic [3:0] CdTens   = 4'(COUNTDOWN_SECONDS / 10);
  localparam logic [3:0] CdOnes   = 4'(COUNTDOWN_SECONDS % 10);
  localparam logic [3:0] GameTens = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] GameOnes = 4'(GAME_SECONDS % 10);

  // Key conditioning
  logic press_left, press_right;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_left (
    .clock(clock),
    .reset(reset),
    .key_n(key_left),
    .press(press_left)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_right (
    .clock(clock),
    .reset(reset),
    .key_n(key_right),
    .press(press_right)
  );

  // Simultaneous events cancel each other.
  logic single_left, single_right, any_press;
  assign single_left  = press_left & ~press_right;
  assign single_right = press_right & ~press_left;
  assign any_press    = single_left | single_right;

  // State and datapath registers
  game_state_e      state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic       tick, at_one;
  logic [1:0] sub_amt;
  logic [7:0] time_next;

  assign tick   = ((state_q == StReady) || (state_q == StPlay)) && (tick_cnt_q == TickMax);
  assign at_one = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign target = lfsr_q[0];

  // Output logic: judging happens combinationally on the registered press
  // pulse so left/right/correct land in the same cycle as the event.
  always_comb begin
    left    = 1'b0;
    right   = 1'b0;
    correct = 1'b0;
    if (state_q == StPlay) begin
      left    = single_left;
      right   = single_right;
      correct = (single_left && (target == SIDE_LEFT)) ||
                (single_right && (target == SIDE_RIGHT));
    end
  end

  // Seconds to remove this cycle while playing.
  always_comb begin
    sub_amt = {1'b0, tick};
`ifdef GAME_JUDGE_PENALTY_EN
    if ((left || right) && !correct) begin
      sub_amt = sub_amt + 2'd2;
    end
`endif
    time_next = bcd_sub(tens_q, ones_q, sub_amt);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_press) state_d = StReady;
      StReady: if (tick && at_one) state_d = StPlay;
      StPlay:  if ((sub_amt != 2'd0) && (time_next == 8'h00)) state_d = StOver;
      StOver:  if (any_press) state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    tick_cnt_d = '0;
    if (state_d == state_q) begin
      if ((state_q == StReady) || (state_q == StPlay)) begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
      end
    end

    tens_d = tens_q;
    ones_d = ones_q;
    lfsr_d = lfsr_q;
    unique case (state_q)
      StIdle: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (any_press) begin
          tens_d = CdTens;
          ones_d = CdOnes;
        end else begin
          tens_d = 4'd0;
          ones_d = 4'd0;
        end
      end
      StReady: begin
        if (tick) begin
          if (at_one) begin
            tens_d = GameTens;
            ones_d = GameOnes;
          end else begin
            {tens_d, ones_d} = bcd_sub(tens_q, ones_q, 2'd1);
          end
        end
      end
      StPlay: begin
        if (left || right) lfsr_d = lfsr_step(lfsr_q);
        if (sub_amt != 2'd0) {tens_d, ones_d} = time_next;
      end
      StOver: begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign cur_state = state_q;
  assign time_tens = tens_q;
  assign time_ones = ones_q;

endmodule

// File: tb/tb_game_judge.sv
// Self-checking bench for game_judge: directed reset/latency/countdown
// checks followed by randomized key activity compared every cycle against a
// behavioural model (integer seconds, sample-window debounce).
module tb_game_judge;

  localparam int unsigned D  = 4;
  localparam int unsigned T  = 10;
  localparam int unsigned CD = 3;
  localparam int unsigned G  = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_left = 1'b1;
  logic       key_right = 1'b1;
  logic       left, right, correct, target;
  logic [1:0] cur_state;
  logic [3:0] time_ones, time_tens;

  int checks = 0;
  int errors = 0;

  game_judge #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES(T),
    .COUNTDOWN_SECONDS(CD),
    .GAME_SECONDS(G)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_left(key_left),
    .key_right(key_right),
    .left(left),
    .right(right),
    .correct(correct),
    .cur_state(cur_state),
    .target(target),
    .time_ones(time_ones),
    .time_tens(time_tens)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_st: 0 idle, 1 ready, 2 play, 3 over; m_rem: remaining seconds.
  int         m_st, m_rem, m_tcnt;
  logic [7:0] m_lfsr;
  logic       m_hist [0:1][0:D+1];  // raw samples, index D+1 newest
  logic       m_db   [0:1];         // debounced level (1 = released)
  logic       m_flip [0:1];         // went to pressed at the last edge
  logic       m_ev   [0:1];         // press pulse visible now

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  task automatic model_reset();
    m_st   = 0;
    m_rem  = 0;
    m_tcnt = 0;
    m_lfsr = 8'hA5;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D + 2; i++) m_hist[k][i] = 1'b1;
      m_db[k]   = 1'b1;
      m_flip[k] = 1'b0;
      m_ev[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic kl, input logic kr);
    logic pl, pr, corr, single, ticking, all_diff;
    logic raw [0:1];
    int   dec;
    pl      = (m_st == 2) && m_ev[0] && !m_ev[1];
    pr      = (m_st == 2) && m_ev[1] && !m_ev[0];
    corr    = (pl && (m_lfsr[0] == 1'b0)) || (pr && (m_lfsr[0] == 1'b1));
    single  = m_ev[0] ^ m_ev[1];
    ticking = ((m_st == 1) || (m_st == 2)) && (m_tcnt == int'(T) - 1);
    case (m_st)
      0: begin
        m_lfsr = lfsr_next(m_lfsr);
        if (single) begin
          m_st   = 1;
          m_rem  = CD;
          m_tcnt = 0;
        end
      end
      1: begin
        if (ticking) begin
          m_tcnt = 0;
          if (m_rem == 1) begin
            m_st  = 2;
            m_rem = G;
          end else begin
            m_rem = m_rem - 1;
          end
        end else begin
          m_tcnt = m_tcnt + 1;
        end
      end
      2: begin
        dec = ticking ? 1 : 0;
`ifdef GAME_JUDGE_PENALTY_EN
        if ((pl || pr) && !corr) dec = dec + 2;
`endif
        if (pl || pr) m_lfsr = lfsr_next(m_lfsr);
        m_tcnt = ticking ? 0 : m_tcnt + 1;
        if (dec > 0) begin
          m_rem = (m_rem > dec) ? m_rem - dec : 0;
          if (m_rem == 0) begin
            m_st   = 3;
            m_tcnt = 0;
          end
        end
      end
      default: begin
        if (single) m_st = 0;
      end
    endcase
    // Debounce: level flips once the D synchronized samples (two edges old)
    // all disagree with it.
    raw[0] = kl;
    raw[1] = kr;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D + 1; i++) m_hist[k][i] = m_hist[k][i+1];
      m_hist[k][D+1] = raw[k];
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (m_hist[k][i] == m_db[k]) all_diff = 1'b0;
      if (all_diff) m_db[k] = ~m_db[k];
      m_ev[k]   = m_flip[k];
      m_flip[k] = all_diff && (m_db[k] == 1'b0);
    end
  endtask

  task automatic compare_all();
    logic el, er, ec;
    el = (m_st == 2) && m_ev[0] && !m_ev[1];
    er = (m_st == 2) && m_ev[1] && !m_ev[0];
    ec = (el && (m_lfsr[0] == 1'b0)) || (er && (m_lfsr[0] == 1'b1));
    check_eq("cur_state", int'(cur_state), m_st);
    check_eq("target", int'(target), int'(m_lfsr[0]));
    check_eq("left", int'(left), int'(el));
    check_eq("right", int'(right), int'(er));
    check_eq("correct", int'(correct), int'(ec));
    check_eq("time_tens", int'(time_tens), m_rem / 10);
    check_eq("time_ones", int'(time_ones), m_rem % 10);
  endtask

  // One clock: drive keys, let the edge happen, advance model, compare.
  task automatic step(input logic kl, input logic kr);
    key_left  = kl;
    key_right = kr;
    @(posedge clock);
    model_step(kl, kr);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, int'(cur_state), 0);
    check_eq({tag, "_target"}, int'(target), 1);
    check_eq({tag, "_pulses"}, int'({left, right, correct}), 0);
    check_eq({tag, "_digits"}, int'({time_tens, time_ones}), 0);
  endtask

  task automatic apply_reset(input string tag);
    key_left  = 1'b1;
    key_right = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int cyc;
    int mode;
    int len;
    int gap;
    logic kl, kr;
    bit did_mid_reset;

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("por");
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b1);

    // Bouncy left press, then stable: READY one cycle after the pulse.
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    n = 0;
    while ((cur_state != 2'b01) && (n < 40)) begin
      step(1'b0, 1'b1);
      n++;
    end
    check_eq("press_to_ready", n, D + 4);
    check_eq("ready_digits", int'({time_tens, time_ones}), 8'h03);

    // Countdown through to PLAY.
    n = 0;
    while ((cur_state != 2'b10) && (n < 100)) begin
      step(1'b1, 1'b1);
      n++;
    end
    check_eq("reach_play", int'(cur_state), 2);
    check_eq("play_digits", int'({time_tens, time_ones}), 8'h12);

    // Pulse latency in PLAY.
    n = 0;
    while ((left != 1'b1) && (n < 40)) begin
      step(1'b0, 1'b1);
      n++;
    end
    check_eq("left_latency", n, D + 3);
    repeat (12) step(1'b1, 1'b1);

    // Randomized key activity, with one asynchronous reset mid-run.
    cyc = 0;
    did_mid_reset = 1'b0;
    while (cyc < 3000) begin
      if (!did_mid_reset && (cyc > 1500)) begin
        did_mid_reset = 1'b1;
        apply_reset("mid");
      end
      mode = $urandom_range(0, 9);
      len  = $urandom_range(1, 12);
      gap  = $urandom_range(1, 12);
      if (mode <= 5) begin
        kl = ($urandom_range(0, 1) == 0);
        kr = ~kl;
      end else if (mode <= 7) begin
        kl = 1'b0;
        kr = 1'b0;
      end else begin
        kl  = 1'b1;
        kr  = 1'b1;
        len = $urandom_range(1, 40);
      end
      for (int i = 0; i < len; i++) step(kl, kr);
      for (int i = 0; i < gap; i++) step(1'b1, 1'b1);
      cyc = cyc + len + gap;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_judge.md
Name: game_judge

Overview:
- Upstream stage of the score/seven-segment path.
- Converts the two raw pushbuttons into clean one-cycle press pulses and runs the game state machine (idle, countdown, play, over).
- Picks a pseudo-random target side and judges each press, producing the left/right/correct pulses consumed by the score counter.
- Also produces the BCD remaining-time digits for the seven-segment decoders.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples needed to accept a level change (5 ms at 50 MHz)
TICK_CYCLES, 50000000, clock cycles per one-second tick
COUNTDOWN_SECONDS, 3, pre-game countdown length (1..9)
GAME_SECONDS, 60, play duration (1..99)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
key_left  in  1  raw left pushbutton, active-low, asynchronous to clock
key_right  in  1  raw right pushbutton, active-low, asynchronous to clock
left  out  1  one-cycle pulse: accepted left press during PLAY
right  out  1  one-cycle pulse: accepted right press during PLAY
correct  out  1  one-cycle pulse, coincident with left/right when the pressed side equals target
cur_state  out  2  00 IDLE, 01 READY, 10 PLAY, 11 OVER
target  out  1  0 = left, 1 = right; side the player must press
time_ones  out  4  BCD ones digit of remaining seconds
time_tens  out  4  BCD tens digit of remaining seconds

Behaviour:
- Reset (reset low, async): all outputs 0 except target.
  - cur_state=IDLE, time digits 0.
  - LFSR=8'hA5, so target=1.
  - Debounce and tick counters 0; debounced levels = released.
- Input path per key: 2-flop synchronizer, then debounce counter.
  - Counter clears whenever the sample equals the debounced level.
  - Debounced level flips when DEBOUNCE_CYCLES consecutive differing samples are seen.
  - A press event is the released->pressed flip of the debounced level.
  - Press event is registered: the pulse appears exactly DEBOUNCE_CYCLES+3 cycles after the raw key falls and stays low.
  - Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Simultaneous left and right events in the same cycle: both discarded. No left/right/correct, no state or target change.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; target = lfsr[0].
  - Steps every cycle in IDLE.
  - In PLAY, steps only in the cycle after an accepted press.
  - Held in READY and OVER.
- IDLE: time digits show 00.
  - Any single press event -> READY.
  - Digits load COUNTDOWN_SECONDS; tick counter clears.
- READY: each tick (tick counter reaches TICK_CYCLES-1, then wraps to 0) decrements the digits.
  - A tick while the value is 01 -> PLAY, digits load GAME_SECONDS (BCD), tick counter clears.
  - Presses in READY are ignored.
- PLAY:
  - A single press event drives left or right high for one cycle.
  - correct=1 in the same cycle iff the pressed side == target.
  - A tick decrements the BCD value: ones 0 -> 9 with tens-1.
  - A tick at value 01 -> value 00 and state OVER.
  - A press in the same cycle as the final tick is still judged.
- OVER: digits hold 00; left/right/correct stay 0.
  - Any single press event -> IDLE.
- The tick counter runs only in READY and PLAY, and clears on every state entry.
- Reset asserted mid-game returns immediately to the reset values. No pulse is emitted on release.

Optional Feature:
- Macro GAME_JUDGE_PENALTY_EN.
- Defined: a wrong press in PLAY (pulse with correct=0) also subtracts 2 s from the remaining time in the same cycle, saturating at 00.
  - Reaching 00 this way -> OVER next cycle.
  - If a tick and a penalty coincide, subtract 3 s total.
- Undefined: wrong presses affect only the pulses; time is driven solely by ticks.

Decomposition:
- Package game_pkg:
  - State encoding constants ST_IDLE/ST_READY/ST_PLAY/ST_OVER (2-bit).
  - LFSR seed 8'hA5.
  - LFSR tap mask.
  - SIDE_LEFT/SIDE_RIGHT constants.
- Sub-module btn_debounce (synchronizer + debounce + press-event output), instantiated once per key.
- The BCD countdown stays inline.

Test Plan (DEBOUNCE_CYCLES=4, TICK_CYCLES=10, COUNTDOWN_SECONDS=3, GAME_SECONDS=12):
- Reset release -> cur_state=00, target=1, left/right/correct=0, digits 00.
- key_left low with 2-cycle bounces, then stable -> exactly one press event, 7 cycles after stable low; cur_state IDLE->READY; digits 03.
- In READY, idle 30 cycles -> digits 03,02,01 at 10-cycle steps; then PLAY with digits 1,2; presses in READY produce no pulses.
- In PLAY with target=1: press right -> right=1, correct=1 for one cycle, target updates next cycle. Press left with target=1 -> left=1, correct=0.
- Both keys pressed in the same cycle during PLAY -> no pulses, target unchanged. Let timer run from 12: digits 12,11,10,09,...,01,00; OVER on the 00 tick; a further press -> IDLE.
- With GAME_JUDGE_PENALTY_EN at digits 01: wrong press -> digits 00, OVER. Without the macro: digits stay 01.
